// File: rtl/param_shift_unit_pkg.sv
// Shared types for the multi-cycle shift unit: op codes, FSM states, bit-cell selects.
// Latency and backpressure are not applicable (types only).
package shift_unit_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_ROR  = 3'b010,
    OP_ROL  = 3'b011,
    OP_LSR  = 3'b100,
    OP_LSL  = 3'b101,
    OP_ASR  = 3'b110
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  // Bit-cell next-value select; "left" is the higher-index neighbour.
  localparam logic [1:0] SEL_HOLD  = 2'd0;
  localparam logic [1:0] SEL_LOAD  = 2'd1;
  localparam logic [1:0] SEL_LEFT  = 2'd2;
  localparam logic [1:0] SEL_RIGHT = 2'd3;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op >= 3'(OP_ROR)) && (op <= 3'(OP_ASR));
  endfunction

endpackage

// File: rtl/param_shift_unit_cell.sv
// One storage bit of the shift register: hold, parallel load, or take a neighbour bit.
// Single-cycle update. There is no backpressure; the top level owns sequencing.
module shift_bit_cell
  import shift_unit_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] sel,
  input  logic       d_load,
  input  logic       d_left,
  input  logic       d_right,
  output logic       q
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= 1'b0;
    end else begin
      case (sel)
        SEL_LOAD:  q <= d_load;
        SEL_LEFT:  q <= d_left;
        SEL_RIGHT: q <= d_right;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/param_shift_unit.sv
// Multi-cycle rotate/shift unit, one bit-position per clock; done arrives amount+1 cycles after accept (1 for LOAD/HOLD).
// start is only accepted while idle; requests made while busy are dropped, not queued.
module param_shift_unit
  import shift_unit_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] q,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  if (WIDTH < 2) begin : g_width_check
    $error("param_shift_unit: WIDTH must be >= 2");
  end

  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH - 1);
  localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

  state_t           state;
  logic [AMT_W-1:0] count;
  logic [2:0]       op_r;
  logic [AMT_W-1:0] amt_eff;
  logic             accept;
  logic             go_shift;
  logic             shift_right;
  logic [1:0]       sel;
  logic             fill_left;
  logic             fill_right;
  logic [WIDTH-1:0] left_in;
  logic [WIDTH-1:0] right_in;

  // Out-of-range amounts only exist when WIDTH is not a power of two.
  if ((2 ** AMT_W) > WIDTH) begin : g_clamp
    assign amt_eff = (amount > AMT_MAX) ? AMT_MAX : amount;
  end else begin : g_no_clamp
    assign amt_eff = amount;
  end

  assign accept      = (state == S_IDLE) && start;
  assign go_shift    = accept && is_shift_op(op) && (amt_eff != '0);
  assign shift_right = (op_r == OP_ROR) || (op_r == OP_LSR) || (op_r == OP_ASR);

  always_comb begin
    sel        = SEL_HOLD;
    fill_left  = 1'b0;
    fill_right = 1'b0;
    if (accept && (op == OP_LOAD)) begin
      sel = SEL_LOAD;
    end else if (state == S_SHIFT) begin
      sel = shift_right ? SEL_LEFT : SEL_RIGHT;
    end
    case (op_r)
      OP_ROR:  fill_left  = q[0];
      OP_ASR:  fill_left  = q[WIDTH-1];
      OP_ROL:  fill_right = q[WIDTH-1];
      default: ;
    endcase
  end

  assign left_in  = {fill_left, q[WIDTH-1:1]};
  assign right_in = {q[WIDTH-2:0], fill_right};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    shift_bit_cell u_cell (
      .clock   (clock),
      .reset   (reset),
      .sel     (sel),
      .d_load  (data_in[i]),
      .d_left  (left_in[i]),
      .d_right (right_in[i]),
      .q       (q[i])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      count     <= '0;
      op_r      <= 3'(OP_HOLD);
      carry_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_r  <= op;
            count <= amt_eff;
            if (op == OP_LOAD) carry_out <= 1'b0;
            state <= go_shift ? S_SHIFT : S_DONE;
          end
        end
        S_SHIFT: begin
          count     <= count - AMT_ONE;
          carry_out <= shift_right ? q[0] : q[WIDTH-1];
          if (count == AMT_ONE) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_param_shift_unit.sv
// Directed bench for param_shift_unit (WIDTH=8) with a reference model feeding an expected-result queue.
module tb_param_shift_unit;

  logic       clock   = 1'b0;
  logic       reset   = 1'b0;
  logic       start   = 1'b0;
  logic [2:0] op      = 3'b000;
  logic [2:0] amount  = 3'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] q;
  logic       carry_out;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] q;
    logic       c;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_q = 8'h00;
  logic       m_c = 1'b0;

  always #5 clock = ~clock;

  param_shift_unit #(.WIDTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .amount    (amount),
    .data_in   (data_in),
    .q         (q),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: apply the op bit by bit from the current modelled register value.
  function automatic logic [8:0] model(input logic [2:0] o, input int a, input logic [7:0] d,
                                       input logic [7:0] q0, input logic c0);
    logic [7:0] qq;
    logic       cc;
    qq = q0;
    cc = c0;
    if (o == 3'b001) begin
      qq = d;
      cc = 1'b0;
    end else if (o >= 3'b010 && o <= 3'b110) begin
      for (int i = 0; i < a; i++) begin
        case (o)
          3'b010: begin cc = qq[0]; qq = {qq[0], qq[7:1]}; end
          3'b011: begin cc = qq[7]; qq = {qq[6:0], qq[7]}; end
          3'b100: begin cc = qq[0]; qq = {1'b0, qq[7:1]}; end
          3'b101: begin cc = qq[7]; qq = {qq[6:0], 1'b0}; end
          default: begin cc = qq[0]; qq = {qq[7], qq[7:1]}; end
        endcase
      end
    end
    return {cc, qq};
  endfunction

  task automatic do_op(input string tag, input logic [2:0] op_v, input int amt,
                       input logic [7:0] din, input int inject);
    exp_t       e;
    exp_t       g;
    logic [8:0] r;
    int         n;
    int         bcnt;
    bit         got;
    r     = model(op_v, amt, din, m_q, m_c);
    e.q   = r[7:0];
    e.c   = r[8];
    e.lat = (op_v >= 3'b010 && op_v <= 3'b110) ? amt : 0;
    m_q   = e.q;
    m_c   = e.c;
    sb.push_back(e);

    @(negedge clock);
    start   = 1'b1;
    op      = op_v;
    amount  = amt[2:0];
    data_in = din;
    @(posedge clock);
    n    = 0;
    bcnt = 0;
    got  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (busy) bcnt++;
      if (done) begin
        got = 1'b1;
        break;
      end
      n++;
      start = (inject >= 0) && (n == inject);
      if (start) begin
        op      = 3'b001;
        data_in = 8'h55;
        amount  = 3'd0;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    g = sb.pop_front();
    if (got) begin
      check({tag, "_latency"}, 32'(n), 32'(g.lat));
      check({tag, "_busy_cycles"}, 32'(bcnt), 32'(g.lat + 1));
      check({tag, "_q"}, 32'(q), 32'(g.q));
      check({tag, "_carry"}, 32'(carry_out), 32'(g.c));
    end
    @(negedge clock);
    check({tag, "_done_single"}, 32'(done), 32'd0);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int dcount;

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    check("reset_q", 32'(q), 32'h00);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_carry", 32'(carry_out), 32'd0);

    do_op("load_ff", 3'b001, 0, 8'hFF, -1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    m_q = 8'h00;
    m_c = 1'b0;
    check("rst2_q", 32'(q), 32'h00);
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_done", 32'(done), 32'd0);
    check("rst2_carry", 32'(carry_out), 32'd0);

    do_op("load_a5", 3'b001, 0, 8'hA5, -1);
    do_op("ror3", 3'b010, 3, 8'h00, -1);
    do_op("load_96", 3'b001, 0, 8'h96, -1);
    do_op("asr2", 3'b110, 2, 8'h00, -1);
    do_op("load_01", 3'b001, 0, 8'h01, -1);
    do_op("lsl7_busy_start", 3'b101, 7, 8'hEE, 3);
    do_op("ror0", 3'b010, 0, 8'h12, -1);
    do_op("reserved_op", 3'b111, 4, 8'h34, -1);
    do_op("lsr1", 3'b100, 1, 8'h00, -1);
    do_op("rol7", 3'b011, 7, 8'h00, -1);
    do_op("load_0f", 3'b001, 0, 8'h0F, -1);

    // ROL by 5 abandoned by reset after two shifts.
    @(negedge clock);
    start  = 1'b1;
    op     = 3'b011;
    amount = 3'd5;
    @(negedge clock);
    start = 1'b0;
    check("midop_busy", 32'(busy), 32'd1);
    @(negedge clock);
    @(negedge clock);
    check("midop_q_after2", 32'(q), 32'h3C);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    m_q = 8'h00;
    m_c = 1'b0;
    check("midop_rst_q", 32'(q), 32'h00);
    check("midop_rst_busy", 32'(busy), 32'd0);
    check("midop_rst_done", 32'(done), 32'd0);
    check("midop_rst_carry", 32'(carry_out), 32'd0);
    dcount = 0;
    repeat (6) begin
      @(negedge clock);
      if (done) dcount++;
    end
    check("midop_no_done", 32'(dcount), 32'd0);

    do_op("load_3c", 3'b001, 0, 8'h3C, -1);
    do_op("asr3_pos", 3'b110, 3, 8'h00, -1);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
